// File: rtl/seq_sub_pkg.sv
// Shared types and helpers for the sliced sequential subtractor.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width: $clog2 of the slice count, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned ns);
    return (ns <= 1) ? 1 : $clog2(ns);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtractor with borrow-in and borrow-out.
module sub_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] w_diff;

  // One extra bit catches the borrow as the sign of the widened difference.
  assign w_diff = {1'b0, a} - {1'b0, b} - (SLICE+1)'(bin);
  assign d      = w_diff[SLICE-1:0];
  assign bout   = w_diff[SLICE];

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle D = A - B - Bin, borrow rippled one SLICE per cycle.
// Optional status flags (Z, N, LTU, LTS) enabled by defining SEQ_SUB_FLAGS_EN.
module seq_subtractor
  import seq_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
`ifdef SEQ_SUB_FLAGS_EN
  output logic             Z,
  output logic             N,
  output logic             LTU,
  output logic             LTS,
`endif
  output logic             OVF
);

  localparam int unsigned NS = WIDTH / SLICE;
  localparam int unsigned CW = cnt_width(NS);

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_a, w_a, r_b, w_b, r_d, w_d;
  logic             r_borrow, w_borrow;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_out_valid, w_out_valid;
  logic             r_bout, w_bout;
  logic             r_ovf, w_ovf;

  logic [SLICE-1:0] w_a_arr [NS];
  logic [SLICE-1:0] w_b_arr [NS];
  logic [SLICE-1:0] w_sl_d;
  logic             w_sl_bout;
  logic [WIDTH-1:0] w_d_ins;
  logic             w_last;

  // Slice views of the operands and the result with the current slice inserted.
  for (genvar g = 0; g < NS; g++) begin : g_slices
    assign w_a_arr[g] = r_a[g*SLICE +: SLICE];
    assign w_b_arr[g] = r_b[g*SLICE +: SLICE];
    assign w_d_ins[g*SLICE +: SLICE] = (r_cnt == CW'(g)) ? w_sl_d : r_d[g*SLICE +: SLICE];
  end

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (w_a_arr[r_cnt]),
    .b    (w_b_arr[r_cnt]),
    .bin  (r_borrow),
    .d    (w_sl_d),
    .bout (w_sl_bout)
  );

  assign w_last   = (r_cnt == CW'(NS-1));
  assign in_ready = (r_state == IDLE) & ~rst;

`ifdef SEQ_SUB_FLAGS_EN
  logic r_z, w_z, r_n, w_n, r_lts, w_lts;
`endif

  always_comb begin
    w_state     = r_state;
    w_a         = r_a;
    w_b         = r_b;
    w_d         = r_d;
    w_borrow    = r_borrow;
    w_cnt       = r_cnt;
    w_out_valid = r_out_valid;
    w_bout      = r_bout;
    w_ovf       = r_ovf;
`ifdef SEQ_SUB_FLAGS_EN
    w_z         = r_z;
    w_n         = r_n;
    w_lts       = r_lts;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a      = A;
          w_b      = B;
          w_borrow = Bin;
          w_cnt    = '0;
          w_state  = CALC;
        end
      end
      CALC: begin
        w_d      = w_d_ins;
        w_borrow = w_sl_bout;
        w_cnt    = r_cnt + CW'(1);
        if (w_last) begin
          w_cnt       = '0;
          w_state     = DONE;
          w_out_valid = 1'b1;
          w_bout      = w_sl_bout;
          w_ovf       = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_sl_d[SLICE-1] ^ r_a[WIDTH-1]);
`ifdef SEQ_SUB_FLAGS_EN
          w_z   = (w_d_ins == '0);
          w_n   = w_sl_d[SLICE-1];
          w_lts = w_sl_d[SLICE-1] ^ w_ovf;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state     = IDLE;
          w_out_valid = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef SEQ_SUB_FLAGS_EN
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_lts       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_a         <= w_a;
      r_b         <= w_b;
      r_d         <= w_d;
      r_borrow    <= w_borrow;
      r_cnt       <= w_cnt;
      r_out_valid <= w_out_valid;
      r_bout      <= w_bout;
      r_ovf       <= w_ovf;
`ifdef SEQ_SUB_FLAGS_EN
      r_z         <= w_z;
      r_n         <= w_n;
      r_lts       <= w_lts;
`endif
    end
  end

  assign D         = r_d;
  assign Bout      = r_bout;
  assign OVF       = r_ovf;
  assign out_valid = r_out_valid;
`ifdef SEQ_SUB_FLAGS_EN
  assign Z   = r_z;
  assign N   = r_n;
  assign LTU = r_bout;
  assign LTS = r_lts;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed self-checking bench for seq_subtractor (WIDTH=32, SLICE=8).
module tb_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
  logic        OVF;
`ifdef SEQ_SUB_FLAGS_EN
  logic        Z, N, LTU, LTS;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
`ifdef SEQ_SUB_FLAGS_EN
    .Z         (Z),
    .N         (N),
    .LTU       (LTU),
    .LTS       (LTS),
`endif
    .OVF       (OVF)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation; returns cycles from accept edge to out_valid, then leaves DONE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic [31:0] ed, input logic eb, input logic eo, input string tag);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 10) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_D"}, D, ed);
    check({tag, "_Bout"}, 32'(Bout), 32'(eb));
    check({tag, "_OVF"}, 32'(OVF), 32'(eo));
`ifdef SEQ_SUB_FLAGS_EN
    check({tag, "_Z"}, 32'(Z), 32'(ed == 32'd0));
    check({tag, "_N"}, 32'(N), 32'(ed[31]));
    check({tag, "_LTU"}, 32'(LTU), 32'(eb));
    check({tag, "_LTS"}, 32'(LTS), 32'(ed[31] ^ eo));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs [8];
  logic [31:0] held_d;

  initial begin
    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h00010000, 32'h00000001, 1'b1, 32'h0000FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[5] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_D", D, 32'd0);
    check("reset_Bout", 32'(Bout), 32'd0);
    check("reset_OVF", 32'(OVF), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].ovf,
            $sformatf("vec%0d", i));

    // Backpressure: result held in DONE while in_valid pulses are ignored.
    A = 32'd9; B = 32'd4; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    held_d = D;
    check("bp_D", held_d, 32'd5);
    for (int c = 0; c < 3; c++) begin
      A = 32'hDEAD0000 + 32'(c); B = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_D", D, 32'd5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    do_op(32'd3, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, "bp_next");

    // Reset asserted on the edge that would compute slice 2.
    A = 32'h00FF00FF; B = 32'h00000001; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_D", D, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("midrst_no_valid", 32'(seen), 32'd0);
    end
    do_op(32'd7, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
